fault_recovery_ctrl: RTL and testbench
======================================

FAULT_RECOVERY_CTRL -- requirements
Module: fault_recovery_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, width of program-counter values.
REQ-002 The block SHALL have parameter MAX_RETRY, default 2, number of consecutive replays allowed before halting.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 8, maximum cycles to wait for recover_ack.
REQ-004 The block SHALL have ports as follows (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- fault_detected, in, 1, fault flag from fault_detector.
- fault_pc, in, PC_W, PC of the faulting instruction.
- fault_opcode, in, 7, opcode of the faulting instruction.
- instr_retired, in, 1, one instruction completed without fault.
- recover_ack, in, 1, pipeline reports that the flush is complete.
- clear_halt, in, 1, software/debug release from halt.
- stall, out, 1, freeze fetch/decode.
- flush, out, 1, one-cycle pipeline flush pulse.
- redirect_valid, out, 1, one-cycle fetch redirect strobe.
- redirect_pc, out, PC_W, replay target.
- halted, out, 1, safe-halt state.
- retry_cnt, out, $clog2(MAX_RETRY+1), consecutive replays so far.

Function
REQ-005 The FSM SHALL have the states IDLE, FLUSH, WAIT_ACK, REPLAY and HALT.
REQ-006 In IDLE, when fault_detected=1 and retry_cnt<MAX_RETRY, the block SHALL:
- capture fault_pc into saved_pc;
- increment retry_cnt;
- go to FLUSH on the next edge.
REQ-007 In IDLE, when fault_detected=1 and retry_cnt==MAX_RETRY, the block SHALL capture fault_pc and go to HALT.
REQ-008 In IDLE, when instr_retired=1 and fault_detected=0, retry_cnt SHALL clear to 0. If both are 1 in the same cycle, the fault SHALL take priority and retry_cnt SHALL NOT clear.
REQ-009 FLUSH SHALL last exactly one cycle with flush=1 and stall=1, then go to WAIT_ACK.
REQ-010 WAIT_ACK behaviour:
- stall=1 throughout.
- recover_ack=1 SHALL move the FSM to REPLAY.
- A timer counts cycles spent in WAIT_ACK; after ACK_TIMEOUT cycles without ack, the FSM SHALL go to HALT.
- An ack in the cycle the timer expires SHALL win, going to REPLAY.
REQ-011 REPLAY SHALL last exactly one cycle with redirect_valid=1, redirect_pc=saved_pc and stall=0, then go to IDLE.
REQ-012 HALT behaviour:
- stall=1 and halted=1.
- clear_halt=1 SHALL return the FSM to IDLE with retry_cnt=0.
- All other inputs SHALL be ignored.
REQ-013 fault_detected SHALL be ignored in every state other than IDLE.
REQ-014 Outputs SHALL be registered, so the FSM responds one cycle after the triggering input. redirect_pc SHALL hold saved_pc whenever the FSM is not in REPLAY.

Reset
REQ-015 While rst_n=0 at a clk edge, the block SHALL set:
- state = IDLE;
- retry_cnt, timer and saved_pc = 0;
- stall, flush, redirect_valid, redirect_pc and halted = 0;
- all log registers = 0.
REQ-016 A reset asserted during any recovery state, including HALT, SHALL abort that recovery immediately, with no flush or redirect pulse emitted afterwards.

Configuration
REQ-017 When macro FAULT_LOG_EN is defined, the block SHALL add these outputs:
- fault_count (16 bits): saturating count of faults accepted per REQ-006/REQ-007;
- last_fault_pc (PC_W bits) and last_fault_opcode (7 bits): captured on each accepted fault.
REQ-018 Without FAULT_LOG_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-019 Package fault_pkg SHALL hold:
- the FSM state encoding;
- RISC-V opcode constants shared with fault_detector;
- the FAULT_CNT_W=16 constant.
REQ-020 The WAIT_ACK timer SHALL be a sub-module ack_timer, with ports clk, rst_n, start, ack and expired.

Verification
REQ-021 Scenario: fault_detected pulse with fault_pc=0x100, then recover_ack 3 cycles after flush. Required response:
- flush high for exactly 1 cycle;
- stall high from FLUSH through WAIT_ACK;
- redirect_valid for 1 cycle with redirect_pc=0x100;
- retry_cnt=1.
REQ-022 Scenario: three back-to-back faults at 0x200, each acked, with no instr_retired in between. Required response: two replays, then halted=1 after the third fault; clear_halt gives halted=0 and retry_cnt=0.
REQ-023 Scenario: fault, then no recover_ack. Required response: halted=1 exactly 8 cycles after entering WAIT_ACK; no redirect_valid.
REQ-024 Scenario: fault_detected and instr_retired together with retry_cnt=1. Required response: retry_cnt=2 and FSM enters FLUSH.
REQ-025 Scenario: rst_n=0 during WAIT_ACK, then released. Required response: all outputs 0, and no flush or redirect afterwards until a new fault.
REQ-026 Scenario (FAULT_LOG_EN defined): faults with opcode 7'b1111111 at PCs 0x10 and 0x20. Required response: fault_count=2, last_fault_pc=0x20, last_fault_opcode=7'h7F.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared definitions for the fault detect/recover path: FSM encoding,
// RISC-V major opcodes used by fault_detector, and log counter width.
package fault_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FLUSH    = 3'd1,
      WAIT_ACK = 3'd2,
      REPLAY   = 3'd3,
      HALT     = 3'd4
   } fault_state_e;

   localparam int FAULT_CNT_W = 16;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fault_recovery_ctrl_ack_timer.sv
// Down-counter bounding the wait for the pipeline's flush acknowledge.
// expired is high during the TIMEOUT-th cycle after start without an ack.
module ack_timer #(
   parameter int TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic ack,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic          running;

   assign expired = running && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         cnt     <= CW'(TIMEOUT - 1);
         running <= 1'b1;
      end else if (running) begin
         if (ack || expired) begin
            running <= 1'b0;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/fault_recovery_ctrl.sv
// Fault recovery sequencer: flush, wait for ack, replay from the faulting PC,
// or safe-halt after too many retries. Define FAULT_LOG_EN to add fault log outputs.
//
// state    | meaning
// IDLE     | normal execution, watching fault_detected
// FLUSH    | one-cycle pipeline flush pulse, fetch stalled
// WAIT_ACK | stalled, waiting for recover_ack or timeout
// REPLAY   | one-cycle redirect to saved_pc
// HALT     | safe halt until clear_halt
module fault_recovery_ctrl
   import fault_pkg::*;
#(
   parameter int PC_W        = 32,
   parameter int MAX_RETRY   = 2,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               fault_detected,
   input  logic [PC_W-1:0]                    fault_pc,
   input  logic [6:0]                         fault_opcode,
   input  logic                               instr_retired,
   input  logic                               recover_ack,
   input  logic                               clear_halt,
   output logic                               stall,
   output logic                               flush,
   output logic                               redirect_valid,
   output logic [PC_W-1:0]                    redirect_pc,
   output logic                               halted,
   output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
`ifdef FAULT_LOG_EN
   ,
   output logic [FAULT_CNT_W-1:0]             fault_count,
   output logic [PC_W-1:0]                    last_fault_pc,
   output logic [6:0]                         last_fault_opcode
`endif
);

   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   fault_state_e    state;
   logic [PC_W-1:0] saved_pc;
   logic            timer_start;
   logic            timer_expired;
   logic            fault_accept;

   assign timer_start  = (state == FLUSH);
   assign fault_accept = (state == IDLE) && fault_detected;
   assign redirect_pc  = saved_pc;

   ack_timer #(
      .TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (timer_start),
      .ack     (recover_ack),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         retry_cnt      <= '0;
         saved_pc       <= '0;
         stall          <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         halted         <= 1'b0;
      end else begin
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (fault_detected) begin
                  saved_pc <= fault_pc;
                  stall    <= 1'b1;
                  if (retry_cnt < RETRY_LIMIT) begin
                     retry_cnt <= retry_cnt + RW'(1);
                     flush     <= 1'b1;
                     state     <= FLUSH;
                  end else begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end
               end else if (instr_retired) begin
                  retry_cnt <= '0;
               end
            end
            FLUSH: state <= WAIT_ACK;
            WAIT_ACK: begin
               // ack beats a timeout landing in the same cycle
               if (recover_ack) begin
                  redirect_valid <= 1'b1;
                  stall          <= 1'b0;
                  state          <= REPLAY;
               end else if (timer_expired) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end
            end
            REPLAY: state <= IDLE;
            HALT: begin
               if (clear_halt) begin
                  retry_cnt <= '0;
                  halted    <= 1'b0;
                  stall     <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FAULT_LOG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_count       <= '0;
         last_fault_pc     <= '0;
         last_fault_opcode <= '0;
      end else if (fault_accept) begin
         if (fault_count != '1) begin
            fault_count <= fault_count + FAULT_CNT_W'(1);
         end
         last_fault_pc     <= fault_pc;
         last_fault_opcode <= fault_opcode;
      end
   end
`else
   logic unused_log_inputs;
   assign unused_log_inputs = ^{fault_opcode, fault_accept};
`endif

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Randomized self-checking bench for fault_recovery_ctrl against a
// transaction-level model of the recovery rules.
module tb_fault_recovery_ctrl;

   localparam int PC_W        = 32;
   localparam int MAX_RETRY   = 2;
   localparam int ACK_TIMEOUT = 8;
   localparam int WIN         = 14;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            fault_detected;
   logic [PC_W-1:0] fault_pc;
   logic [6:0]      fault_opcode;
   logic            instr_retired;
   logic            recover_ack;
   logic            clear_halt;
   logic            stall;
   logic            flush;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            halted;
   logic [1:0]      retry_cnt;
`ifdef FAULT_LOG_EN
   logic [15:0]     fault_count;
   logic [PC_W-1:0] last_fault_pc;
   logic [6:0]      last_fault_opcode;
`endif

   always #5 clk = ~clk;

   fault_recovery_ctrl #(
      .PC_W        (PC_W),
      .MAX_RETRY   (MAX_RETRY),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fault_detected    (fault_detected),
      .fault_pc          (fault_pc),
      .fault_opcode      (fault_opcode),
      .instr_retired     (instr_retired),
      .recover_ack       (recover_ack),
      .clear_halt        (clear_halt),
      .stall             (stall),
      .flush             (flush),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .halted            (halted),
      .retry_cnt         (retry_cnt)
`ifdef FAULT_LOG_EN
      ,
      .fault_count       (fault_count),
      .last_fault_pc     (last_fault_pc),
      .last_fault_opcode (last_fault_opcode)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int              m_retry;
   bit              m_halt;
   logic [PC_W-1:0] m_saved;
   int              m_fcount;
   logic [PC_W-1:0] m_last_pc;
   logic [6:0]      m_last_opc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_retry    = 0;
      m_halt     = 0;
      m_saved    = '0;
      m_fcount   = 0;
      m_last_pc  = '0;
      m_last_opc = '0;
   endtask

   // Expected observations for one fault presented in the window after it is sampled.
   task automatic model_fault(input logic [PC_W-1:0] pc, input logic [6:0] opc, input int ack_at,
                              output int e_flush, output int e_redir, output logic [PC_W-1:0] e_rpc,
                              output int e_halt_at, output int e_stall, output int e_noise_hi);
      e_flush = 0; e_redir = 0; e_rpc = '0; e_halt_at = -1; e_stall = 0;
      if (m_halt) begin
         e_halt_at = 0; e_stall = WIN; e_noise_hi = WIN - 1;
         return;
      end
      m_saved    = pc;
      m_last_pc  = pc;
      m_last_opc = opc;
      if (m_fcount < 65535) m_fcount++;
      if (m_retry >= MAX_RETRY) begin
         m_halt = 1; e_halt_at = 0; e_stall = WIN; e_noise_hi = WIN - 1;
      end else begin
         m_retry++;
         e_flush = 1;
         if (ack_at >= 1 && ack_at <= ACK_TIMEOUT) begin
            e_redir = 1; e_rpc = pc; e_stall = ack_at + 1; e_noise_hi = ack_at;
         end else begin
            m_halt = 1; e_halt_at = ACK_TIMEOUT + 1; e_stall = WIN; e_noise_hi = ACK_TIMEOUT;
         end
      end
   endtask

   // Drive one fault, watch WIN cycles, compare against the model.
   task automatic fault_scenario(input string tag, input logic [PC_W-1:0] pc, input logic [6:0] opc,
                                 input int ack_at, input bit with_retire);
      int e_flush, e_redir, e_halt_at, e_stall, noise_hi;
      logic [PC_W-1:0] e_rpc;
      int n_flush, n_redir, halt_at, n_stall;
      logic [PC_W-1:0] rpc;
      model_fault(pc, opc, ack_at, e_flush, e_redir, e_rpc, e_halt_at, e_stall, noise_hi);
      fault_detected = 1'b1; fault_pc = pc; fault_opcode = opc; instr_retired = with_retire;
      tick();
      fault_detected = 1'b0; instr_retired = 1'b0;
      n_flush = 0; n_redir = 0; halt_at = -1; n_stall = 0; rpc = '0;
      for (int k = 0; k < WIN; k++) begin
         if (flush) n_flush++;
         if (redirect_valid) begin n_redir++; rpc = redirect_pc; end
         if (stall) n_stall++;
         if (halted && halt_at < 0) halt_at = k;
         recover_ack = (k == ack_at);
         // faults and retirements while recovering must be ignored
         fault_detected = (k >= 1 && k <= noise_hi) ? 1'($urandom_range(0, 1)) : 1'b0;
         instr_retired  = (k >= 1 && k <= noise_hi) ? 1'($urandom_range(0, 1)) : 1'b0;
         fault_pc       = $urandom;
         fault_opcode   = 7'($urandom);
         tick();
      end
      recover_ack = 1'b0; fault_detected = 1'b0; instr_retired = 1'b0;
      n_checks += 8;
      if (n_flush !== e_flush) begin n_fail++; $display("FAIL %s flush_pulses: got %0d want %0d", tag, n_flush, e_flush); end
      if (n_redir !== e_redir) begin n_fail++; $display("FAIL %s redirect_pulses: got %0d want %0d", tag, n_redir, e_redir); end
      if (rpc !== e_rpc) begin n_fail++; $display("FAIL %s redirect_target: got %h want %h", tag, rpc, e_rpc); end
      if (halt_at !== e_halt_at) begin n_fail++; $display("FAIL %s halt_cycle: got %0d want %0d", tag, halt_at, e_halt_at); end
      if (n_stall !== e_stall) begin n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, n_stall, e_stall); end
      if (int'(retry_cnt) !== m_retry) begin n_fail++; $display("FAIL %s retry_cnt: got %0d want %0d", tag, retry_cnt, m_retry); end
      if (halted !== m_halt) begin n_fail++; $display("FAIL %s halted: got %b want %b", tag, halted, m_halt); end
      if (redirect_pc !== m_saved) begin n_fail++; $display("FAIL %s redirect_pc_hold: got %h want %h", tag, redirect_pc, m_saved); end
`ifdef FAULT_LOG_EN
      n_checks += 3;
      if (int'(fault_count) !== m_fcount) begin n_fail++; $display("FAIL %s fault_count: got %0d want %0d", tag, fault_count, m_fcount); end
      if (last_fault_pc !== m_last_pc) begin n_fail++; $display("FAIL %s last_fault_pc: got %h want %h", tag, last_fault_pc, m_last_pc); end
      if (last_fault_opcode !== m_last_opc) begin n_fail++; $display("FAIL %s last_fault_opcode: got %h want %h", tag, last_fault_opcode, m_last_opc); end
`endif
   endtask

   task automatic pulse_retire(input string tag);
      instr_retired = 1'b1;
      tick();
      instr_retired = 1'b0;
      if (!m_halt) m_retry = 0;
      n_checks++;
      if (int'(retry_cnt) !== m_retry) begin n_fail++; $display("FAIL %s retire_retry_cnt: got %0d want %0d", tag, retry_cnt, m_retry); end
   endtask

   task automatic pulse_clear(input string tag);
      clear_halt = 1'b1;
      tick();
      clear_halt = 1'b0;
      if (m_halt) begin m_halt = 0; m_retry = 0; end
      n_checks += 3;
      if (halted !== m_halt) begin n_fail++; $display("FAIL %s clear_halted: got %b want %b", tag, halted, m_halt); end
      if (int'(retry_cnt) !== m_retry) begin n_fail++; $display("FAIL %s clear_retry_cnt: got %0d want %0d", tag, retry_cnt, m_retry); end
      if (stall !== m_halt) begin n_fail++; $display("FAIL %s clear_stall: got %b want %b", tag, stall, m_halt); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fault_detected = 1'b0; fault_pc = '0; fault_opcode = '0;
      instr_retired = 1'b0; recover_ack = 1'b0; clear_halt = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      model_reset();
      n_checks++;
      if ({stall, flush, redirect_valid, halted, retry_cnt, redirect_pc} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got stall=%b flush=%b rv=%b halted=%b retry=%0d pc=%h want all 0",
                  stall, flush, redirect_valid, halted, retry_cnt, redirect_pc);
      end
`ifdef FAULT_LOG_EN
      n_checks++;
      if ({fault_count, last_fault_pc, last_fault_opcode} !== '0) begin
         n_fail++; $display("FAIL reset_log: got cnt=%0d pc=%h opc=%h want 0", fault_count, last_fault_pc, last_fault_opcode);
      end
`endif
   endtask

   task automatic test_single_replay();
      fault_scenario("single_replay", 32'h100, 7'h03, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      pulse_retire("b2b_pre");
      fault_scenario("b2b_1", 32'h200, 7'h23, 2, 1'b0);
      fault_scenario("b2b_2", 32'h200, 7'h23, 2, 1'b0);
      fault_scenario("b2b_3", 32'h200, 7'h23, 2, 1'b0);
      fault_scenario("b2b_in_halt", 32'h300, 7'h33, 2, 1'b0);
      pulse_clear("b2b_clear");
   endtask

   task automatic test_timeout();
      fault_scenario("timeout", 32'h400, 7'h13, 0, 1'b0);
      pulse_clear("timeout_clear");
   endtask

   task automatic test_fault_with_retire();
      fault_scenario("retire_pri_1", 32'h500, 7'h63, 1, 1'b0);
      fault_scenario("retire_pri_2", 32'h504, 7'h63, 2, 1'b1);
      pulse_retire("retire_clear");
   endtask

   task automatic test_ack_boundary();
      fault_scenario("ack_last_cycle", 32'h600, 7'h6F, ACK_TIMEOUT, 1'b0);
      pulse_retire("ack_bnd_retire");
      fault_scenario("ack_too_late", 32'h604, 7'h6F, ACK_TIMEOUT + 1, 1'b0);
      pulse_clear("ack_bnd_clear");
   endtask

   task automatic test_reset_mid(input string tag, input bit from_halt);
      int n_act;
      if (from_halt) begin
         fault_scenario("pre_halt_1", 32'h700, 7'h37, 1, 1'b0);
         fault_scenario("pre_halt_2", 32'h704, 7'h37, 1, 1'b0);
         fault_scenario("pre_halt_3", 32'h708, 7'h37, 1, 1'b0);
      end else begin
         fault_detected = 1'b1; fault_pc = 32'h800;
         tick();
         fault_detected = 1'b0;
         tick(); tick();
      end
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({stall, flush, redirect_valid, halted, retry_cnt, redirect_pc} !== '0) begin
         n_fail++;
         $display("FAIL %s in_reset_outputs: got stall=%b flush=%b rv=%b halted=%b retry=%0d pc=%h want all 0",
                  tag, stall, flush, redirect_valid, halted, retry_cnt, redirect_pc);
      end
      rst_n = 1'b1;
      model_reset();
      n_act = 0;
      for (int i = 0; i < 20; i++) begin
         recover_ack = (i == 2);
         tick();
         if (flush || redirect_valid || stall || halted) n_act++;
      end
      recover_ack = 1'b0;
      n_checks++;
      if (n_act !== 0) begin n_fail++; $display("FAIL %s post_reset_activity: got %0d active cycles want 0", tag, n_act); end
   endtask

   task automatic test_log();
`ifdef FAULT_LOG_EN
      test_reset();
      fault_scenario("log_1", 32'h10, 7'h7F, 2, 1'b0);
      fault_scenario("log_2", 32'h20, 7'h7F, 2, 1'b0);
      n_checks++;
      if (fault_count !== 16'd2 || last_fault_pc !== 32'h20 || last_fault_opcode !== 7'h7F) begin
         n_fail++;
         $display("FAIL log_fixed: got cnt=%0d pc=%h opc=%h want 2 00000020 7f", fault_count, last_fault_pc, last_fault_opcode);
      end
      pulse_retire("log_retire");
`endif
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            fault_scenario("random_fault", $urandom, 7'($urandom), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
         end else if (r <= 7) begin
            pulse_retire("random_retire");
         end else begin
            pulse_clear("random_clear");
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_replay();
      test_back_to_back();
      test_timeout();
      test_fault_with_retire();
      test_ack_boundary();
      test_reset_mid("reset_wait_ack", 1'b0);
      test_reset_mid("reset_halt", 1'b1);
      test_log();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
